// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: steps one shared BCD digit adder over NDIG packed digits, least-significant digit first
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err,
  output logic              busy
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [NDIG-1:0][3:0] a_r, b_r, sum_r;
  logic [IW-1:0] idx;
  logic carry, last, accept, c_nx;
  logic [3:0] a_d, b_d, digit;
  logic [4:0] t, tc;
  assign accept = state == IDLE && in_valid;
  assign last = idx == IW'(NDIG - 1);
  assign a_d = a_r[idx];
  assign b_d = b_r[idx];
  assign t = {1'b0, a_d} + {1'b0, b_d} + {4'd0, carry};
  assign tc = t + 5'd6;
  assign c_nx = t > 5'd9;
  assign digit = c_nx ? tc[3:0] : t[3:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign sum = sum_r;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = accept ? ADD :
               (state == ADD && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      idx <= '0;
      cout <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      carry <= cin;
      idx <= '0;
      sum_r <= '0;
      cout <= 1'b0;
      err <= 1'b0;
    end else if (state == ADD) begin
      sum_r[idx] <= digit;
      carry <= c_nx;
      idx <= last ? '0 : idx + 1'b1;
      err <= err | (a_d > 4'd9) | (b_d > 4'd9);
      cout <= last ? c_nx : cout;
    end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed and random checks of the serial BCD adder against a digit-rule model
module tb_bcd_serial_add_ctrl;
  localparam int NDIG = 4;
  localparam int W = 4 * NDIG;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic in_ready, out_valid, cout, err, busy;
  logic [W-1:0] sum;
  int tests = 0;
  int fails = 0;
  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] s;
    int cy;
    bit e;
    s = '0;
    cy = int'(c);
    e = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      int xd, yd, t;
      xd = int'(x[4*i +: 4]);
      yd = int'(y[4*i +: 4]);
      t = xd + yd + cy;
      e = e | (xd > 9) | (yd > 9);
      s[4*i +: 4] = 4'((t > 9) ? (t + 6) % 16 : t);
      cy = (t > 9) ? 1 : 0;
    end
    return {e, cy[0], s};
  endfunction
  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction
  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                     input int hold, input bit keep, output logic [W+1:0] got);
    logic [W+1:0] m;
    int n;
    m = model(x, y, c);
    n = 0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    tick;
    in_valid = keep;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    chk("busy_add", 32'(busy), 32'd1);
    while (!out_valid && n < 3 * NDIG) begin
      tick;
      n++;
      if (keep) begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    chk("latency", 32'(n), 32'(NDIG));
    chk("sum", 32'(sum), 32'(m[W-1:0]));
    chk("cout", 32'(cout), 32'(m[W]));
    chk("err", 32'(err), 32'(m[W+1]));
    got = {err, cout, sum};
    out_ready = 1'b0;
    repeat (hold) begin
      tick;
      chk("hold_flags", {29'd0, out_valid, in_ready, cout}, {29'd0, 1'b1, 1'b0, m[W]});
      chk("hold_sum", 32'(sum), 32'(m[W-1:0]));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("released", {29'd0, out_valid, busy, in_ready}, 32'b001);
  endtask
  initial begin
    logic [W+1:0] r;
    logic [W-1:0] x, y;
    tick;
    tick;
    rst_n = 1'b1;
    chk("reset_flags", {27'd0, in_ready, out_valid, busy, cout, err}, 32'b10000);
    chk("reset_sum", 32'(sum), 32'd0);
    run(16'h0099, 16'h0001, 1'b0, 0, 1'b0, r);
    chk("t1", 32'(r), {14'd0, 2'b00, 16'h0100});
    run(16'h9999, 16'h0001, 1'b0, 0, 1'b0, r);
    chk("t2a", 32'(r), {14'd0, 2'b01, 16'h0000});
    run(16'h9999, 16'h9999, 1'b1, 1, 1'b0, r);
    chk("t2b", 32'(r), {14'd0, 2'b01, 16'h9999});
    run(16'h0002, 16'h000E, 1'b0, 0, 1'b0, r);
    chk("t3_err", 32'(r), {14'd0, 2'b10, 16'h0016});
    run(16'h1234, 16'h4321, 1'b0, 10, 1'b0, r);
    chk("t3_clear", 32'(r), {14'd0, 2'b00, 16'h5555});
    run(16'h0500, 16'h0500, 1'b1, 0, 1'b0, r);
    chk("t4_b2b", 32'(r), {14'd0, 2'b00, 16'h1001});
    a = 16'h1111;
    b = 16'h2222;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_flags", {27'd0, in_ready, out_valid, busy, cout, err}, 32'b10000);
    chk("abort_sum", 32'(sum), 32'd0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    tick;
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("reset_wins", {29'd0, in_ready, busy, out_valid}, 32'b100);
    run(16'h0808, 16'h0303, 1'b1, 0, 1'b0, r);
    chk("after_abort", 32'(r), {14'd0, 2'b00, 16'h1112});
    for (int k = 0; k < 6; k++) begin
      run(rand_bcd(), rand_bcd(), 1'($urandom), $urandom_range(0, 2), 1'b1, r);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      x = ($urandom_range(0, 3) == 0) ? W'($urandom) : rand_bcd();
      y = ($urandom_range(0, 3) == 0) ? W'($urandom) : rand_bcd();
      run(x, y, 1'($urandom), $urandom_range(0, 3), 1'b0, r);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
